// File: rtl/ysyx_22040228clint_resp_pkg.sv
// Shared CLINT definitions: address window, register offsets, AXI size codes,
// FSM encodings and the byte-lane merge helper.
package ysyx_22040228clint_resp_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned MASK_W   = 8;
  localparam int unsigned SIZE_W   = 3;
  localparam int unsigned DW_IDX_W = 13;
  localparam int unsigned PRESC_W  = 16;

  localparam logic [XLEN-1:0] CLINT_START = 64'h0000_0000_0200_0000;
  localparam logic [XLEN-1:0] CLINT_LEN   = 64'h0000_0000_0001_0000;
  localparam logic [XLEN-1:0] CLINT_END   = CLINT_START + CLINT_LEN - 64'd1;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  localparam logic [SIZE_W-1:0] AXI_SIZE_BYTES_1 = 3'b000;
  localparam logic [SIZE_W-1:0] AXI_SIZE_BYTES_2 = 3'b001;
  localparam logic [SIZE_W-1:0] AXI_SIZE_BYTES_4 = 3'b010;
  localparam logic [SIZE_W-1:0] AXI_SIZE_BYTES_8 = 3'b011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } clint_state_e;

  // Byte i of the result comes from wdata when mask[i] is set, else from old.
  function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0]   old,
                                                  input logic [XLEN-1:0]   wdata,
                                                  input logic [MASK_W-1:0] mask);
    logic [XLEN-1:0] res;
    res = old;
    for (int i = 0; i < int'(MASK_W); i++) begin
      if (mask[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_22040228clint_mtime.sv
// Machine timer: prescaler plus 64-bit counter with a byte-masked write port.
// A write beats a same-cycle increment and restarts the prescaler.
module ysyx_22040228clint_mtime
  import ysyx_22040228clint_resp_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [MASK_W-1:0] mask,
  input  logic [XLEN-1:0]   data,
  output logic [XLEN-1:0]   mtime
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] prescaler;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prescaler <= '0;
      mtime     <= '0;
    end else if (we) begin
      mtime     <= merge_bytes(mtime, data, mask);
      prescaler <= '0;
    end else if (prescaler == PRESC_MAX) begin
      mtime     <= mtime + 64'd1;
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/ysyx_22040228clint_resp.sv
// CLINT responder on the core MMIO request port: msip/mtimecmp/mtime registers,
// single-beat accesses completed by a one-cycle finish pulse.
module ysyx_22040228clint_resp
  import ysyx_22040228clint_resp_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = CLINT_START,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_data,
  input  logic [MASK_W-1:0] req_mask,
  input  logic [SIZE_W-1:0] req_size,
  input  logic              req_we,
  input  logic              req_re,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_finish,
  output logic              resp_err,
  output logic              timer_irq,
  output logic              soft_irq
);

  localparam logic [XLEN-1:0]     WIN_END      = BASE_ADDR + (CLINT_LEN - 64'd1);
  localparam logic [DW_IDX_W-1:0] MSIP_IDX     = MSIP_OFF[15:3];
  localparam logic [DW_IDX_W-1:0] MTIMECMP_IDX = MTIMECMP_OFF[15:3];
  localparam logic [DW_IDX_W-1:0] MTIME_IDX    = MTIME_OFF[15:3];

  clint_state_e state, state_nxt;

  logic [XLEN-1:0] mtime, mtimecmp;
  logic            msip;

  logic            req_c, out_of_win_c, misaligned_c, err_c;
  logic            hit_msip_c, hit_cmp_c, hit_time_c;
  logic            wr_msip_c, wr_cmp_c, wr_time_c;
  logic [XLEN-1:0] rdata_c, data_nxt;
  logic            finish_nxt, err_nxt;

  // Address decode, legality and read mux.
  always_comb begin
    req_c        = req_we | req_re;
    out_of_win_c = (req_addr < BASE_ADDR) || (req_addr > WIN_END);
    unique case (req_size)
      AXI_SIZE_BYTES_1: misaligned_c = 1'b0;
      AXI_SIZE_BYTES_2: misaligned_c = req_addr[0];
      AXI_SIZE_BYTES_4: misaligned_c = |req_addr[1:0];
      AXI_SIZE_BYTES_8: misaligned_c = |req_addr[2:0];
      default:          misaligned_c = 1'b1;
    endcase
    err_c      = out_of_win_c | (req_we & req_re) | misaligned_c;
    hit_msip_c = (req_addr[15:3] == MSIP_IDX);
    hit_cmp_c  = (req_addr[15:3] == MTIMECMP_IDX);
    hit_time_c = (req_addr[15:3] == MTIME_IDX);
    rdata_c    = '0;
    if (hit_msip_c)      rdata_c = {63'd0, msip};
    else if (hit_cmp_c)  rdata_c = mtimecmp;
    else if (hit_time_c) rdata_c = mtime;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      resp_finish <= 1'b0;
      resp_err    <= 1'b0;
      resp_data   <= '0;
    end else begin
      state       <= state_nxt;
      resp_finish <= finish_nxt;
      resp_err    <= err_nxt;
      resp_data   <= data_nxt;
    end
  end

  // Next state, response and register write strobes.
  always_comb begin
    state_nxt  = state;
    finish_nxt = 1'b0;
    err_nxt    = 1'b0;
    data_nxt   = resp_data;
    wr_msip_c  = 1'b0;
    wr_cmp_c   = 1'b0;
    wr_time_c  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_c) begin
          state_nxt  = ST_ACK;
          finish_nxt = 1'b1;
          err_nxt    = err_c;
          if (err_c) begin
            data_nxt = '0;
          end else if (req_re) begin
            data_nxt = rdata_c;
          end else begin
            data_nxt  = '0;
            wr_msip_c = hit_msip_c & req_mask[0];
            wr_cmp_c  = hit_cmp_c & (|req_mask);
            wr_time_c = hit_time_c & (|req_mask);
          end
        end
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      msip     <= 1'b0;
      mtimecmp <= '1;
    end else begin
      if (wr_msip_c) msip <= req_data[0];
      if (wr_cmp_c)  mtimecmp <= merge_bytes(mtimecmp, req_data, req_mask);
    end
  end

  ysyx_22040228clint_mtime #(
    .TICK_DIV (TICK_DIV)
  ) u_mtime (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_time_c),
    .mask  (req_mask),
    .data  (req_data),
    .mtime (mtime)
  );

  assign timer_irq = (mtime >= mtimecmp);
  assign soft_irq  = msip;

endmodule
